// File: rtl/vc_fifo.sv
// +--------------------------------------------------------------------------+
// | vc_fifo: 12-bit transaction buffer feeding the referee, with programmable |
// | almost-full/almost-empty flags. Option: VC_FIFO_WATERMARK_EN (peak_count). |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module vc_fifo #(
  parameter int LINE_SIZE  = 12,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3,
  parameter int AF_DEFAULT = 6,
  parameter int AE_DEFAULT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic [ADDR_W:0]      thr_almost_full,
  input  logic [ADDR_W:0]      thr_almost_empty,
  input  logic                 push,
  input  logic                 pop,
  input  logic [LINE_SIZE-1:0] data_in,
  output logic [LINE_SIZE-1:0] data_out,
  output logic                 full,
  output logic                 empty_f,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [ADDR_W:0]      fifo_count,
  output logic                 error
`ifdef VC_FIFO_WATERMARK_EN
  ,
  output logic [ADDR_W:0]      peak_count
`endif
);

  localparam logic [ADDR_W:0]   c_DEPTH  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   c_ONE    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   c_AF_DEF = (ADDR_W+1)'(AF_DEFAULT);
  localparam logic [ADDR_W:0]   c_AE_DEF = (ADDR_W+1)'(AE_DEFAULT);
  localparam logic [ADDR_W-1:0] c_PTR_ONE = (ADDR_W)'(1);

  logic [LINE_SIZE-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0]    r_wr_ptr;
  logic [ADDR_W-1:0]    r_rd_ptr;
  logic [ADDR_W:0]      r_count;
  logic [ADDR_W:0]      r_af_thr;
  logic [ADDR_W:0]      r_ae_thr;
  logic [LINE_SIZE-1:0] r_data_out;
  logic                 r_error;

  logic                 w_pop_ok;
  logic                 w_push_ok;
  logic [ADDR_W:0]      w_count_nxt;

  // A push into a full FIFO is still legal when a pop frees a slot the same edge.
  assign w_pop_ok  = pop && (r_count != '0);
  assign w_push_ok = push && ((r_count != c_DEPTH) || w_pop_ok);

  always_comb begin
    w_count_nxt = r_count;
    if (w_push_ok && !w_pop_ok) begin
      w_count_nxt = r_count + c_ONE;
    end else if (!w_push_ok && w_pop_ok) begin
      w_count_nxt = r_count - c_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_data_out <= '0;
      r_error    <= 1'b0;
      r_af_thr   <= c_AF_DEF;
      r_ae_thr   <= c_AE_DEF;
    end else begin
      r_count <= w_count_nxt;
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop_ok) begin
        r_data_out <= r_mem[r_rd_ptr];
        r_rd_ptr   <= r_rd_ptr + c_PTR_ONE;
      end
      if ((push && !w_push_ok) || (pop && !w_pop_ok)) begin
        r_error <= 1'b1;
      end
      if (init) begin
        r_af_thr <= thr_almost_full;
        r_ae_thr <= thr_almost_empty;
      end
    end
  end

`ifdef VC_FIFO_WATERMARK_EN
  logic [ADDR_W:0] r_peak;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_peak <= '0;
    end else if (init) begin
      r_peak <= '0;
    end else if (w_count_nxt > r_peak) begin
      r_peak <= w_count_nxt;
    end
  end

  assign peak_count = r_peak;
`endif

  assign data_out     = r_data_out;
  assign fifo_count   = r_count;
  assign error        = r_error;
  assign full         = (r_count == c_DEPTH);
  assign empty_f      = (r_count == '0);
  assign almost_full  = (r_count >= r_af_thr);
  assign almost_empty = (r_count <= r_ae_thr) && (r_count != '0);

endmodule

`default_nettype wire

// File: tb/tb_vc_fifo.sv
// Scoreboard bench for vc_fifo: directed vectors, expected read words queued by stimulus.
`default_nettype none

module tb_vc_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        init;
  logic [3:0]  thr_almost_full;
  logic [3:0]  thr_almost_empty;
  logic        push;
  logic        pop;
  logic [11:0] data_in;
  logic [11:0] data_out;
  logic        full;
  logic        empty_f;
  logic        almost_full;
  logic        almost_empty;
  logic [3:0]  fifo_count;
  logic        error;
`ifdef VC_FIFO_WATERMARK_EN
  logic [3:0]  peak_count;
`endif

  int n_pass = 0;
  int n_tot  = 0;
  logic [11:0] exp_q[$];
  bit m_acc;

  vc_fifo dut (
    .clk(clk), .reset(reset), .init(init),
    .thr_almost_full(thr_almost_full), .thr_almost_empty(thr_almost_empty),
    .push(push), .pop(pop), .data_in(data_in), .data_out(data_out),
    .full(full), .empty_f(empty_f), .almost_full(almost_full),
    .almost_empty(almost_empty), .fifo_count(fifo_count), .error(error)
`ifdef VC_FIFO_WATERMARK_EN
    , .peak_count(peak_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: any accepted pop must produce the oldest queued word one edge later.
  always begin
    @(posedge clk);
    m_acc = pop && !empty_f && !reset;
    if (m_acc) begin
      #1;
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", 1, 0);
      end else begin
        chk("data_out", int'(data_out), int'(exp_q.pop_front()));
      end
    end
  end

  // One clock of stimulus; exp_pop queues the word the pop should return.
  task automatic cyc(input bit pu, input bit po, input logic [11:0] d,
                     input bit exp_pop = 1'b0, input logic [11:0] ev = '0);
    @(negedge clk);
    push = pu; pop = po; data_in = d;
    if (exp_pop) exp_q.push_back(ev);
    @(posedge clk);
    #2;
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; init = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0;
    thr_almost_full = '0; thr_almost_empty = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_empty", int'(empty_f), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_dout", int'(data_out), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_af", int'(almost_full), 0);
    chk("rst_ae", int'(almost_empty), 0);

    // Basic ordering and latency
    cyc(1, 0, 12'hDE4);
    chk("ae_at_1", int'(almost_empty), 1);
    cyc(1, 0, 12'h96C);
    cyc(1, 0, 12'h16E);
    chk("count_3", int'(fifo_count), 3);
    cyc(0, 1, '0, 1, 12'hDE4);
    cyc(0, 1, '0, 1, 12'h96C);
    cyc(0, 1, '0, 1, 12'h16E);
    chk("empty_after_drain", int'(empty_f), 1);

    // Fill, thresholds, overflow
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 0, 12'(i));
      chk("fill_count", int'(fifo_count), i);
      chk("fill_af", int'(almost_full), (i >= 6) ? 1 : 0);
      chk("fill_full", int'(full), (i == 8) ? 1 : 0);
    end
`ifdef VC_FIFO_WATERMARK_EN
    chk("peak_8", int'(peak_count), 8);
`endif
    cyc(1, 0, 12'h0FF);
    chk("ovf_error", int'(error), 1);
    chk("ovf_count", int'(fifo_count), 8);
    for (int i = 1; i <= 8; i++) cyc(0, 1, '0, 1, 12'(i));
    chk("ovf_drained", int'(empty_f), 1);

    // Push+pop while full
    do_reset();
    for (int i = 1; i <= 8; i++) cyc(1, 0, 12'(i));
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 12'h100 + 12'(i), 1, 12'(i + 1));
      chk("pp_full", int'(full), 1);
      chk("pp_error", int'(error), 0);
    end
    for (int i = 5; i <= 8; i++) cyc(0, 1, '0, 1, 12'(i));
    for (int i = 0; i < 4; i++) cyc(0, 1, '0, 1, 12'h100 + 12'(i));
    chk("pp_drained", int'(empty_f), 1);
    chk("pp_error_end", int'(error), 0);

    // Programmed thresholds 3/1
    @(negedge clk);
    init = 1'b1; thr_almost_full = 4'd3; thr_almost_empty = 4'd1;
    @(negedge clk);
    init = 1'b0;
    cyc(1, 0, 12'hA01);
    chk("thr_ae_c1", int'(almost_empty), 1);
    chk("thr_af_c1", int'(almost_full), 0);
    cyc(1, 0, 12'hA02);
    chk("thr_ae_c2", int'(almost_empty), 0);
    chk("thr_af_c2", int'(almost_full), 0);
    cyc(1, 0, 12'hA03);
    chk("thr_ae_c3", int'(almost_empty), 0);
    chk("thr_af_c3", int'(almost_full), 1);
    cyc(0, 1, '0, 1, 12'hA01);
    cyc(0, 1, '0, 1, 12'hA02);
    cyc(0, 1, '0, 1, 12'hA03);
    chk("thr_err_before", int'(error), 0);
    cyc(0, 1, '0);
    chk("unf_error", int'(error), 1);
    chk("unf_dout", int'(data_out), 12'hA03);

    // Push+pop on empty: push taken, pop rejected
    cyc(1, 1, 12'h0AB);
    chk("pe_count", int'(fifo_count), 1);
    chk("pe_dout", int'(data_out), 12'hA03);
    cyc(0, 1, '0, 1, 12'h0AB);

    // Reset mid-operation with pop pending
    for (int i = 0; i < 5; i++) cyc(1, 0, 12'h200 + 12'(i));
    chk("pre_rst_count", int'(fifo_count), 5);
    @(negedge clk);
    pop = 1'b1; reset = 1'b1;
    #1;
    chk("mid_rst_count", int'(fifo_count), 0);
    chk("mid_rst_empty", int'(empty_f), 1);
    chk("mid_rst_error", int'(error), 0);
    chk("mid_rst_dout", int'(data_out), 0);
`ifdef VC_FIFO_WATERMARK_EN
    chk("mid_rst_peak", int'(peak_count), 0);
`endif
    @(negedge clk);
    pop = 1'b0; reset = 1'b0;
    cyc(1, 0, 12'h301);
    cyc(1, 0, 12'h302);
    chk("thr_def_ae", int'(almost_empty), 1);
    for (int i = 3; i <= 6; i++) cyc(1, 0, 12'h300 + 12'(i));
    chk("thr_def_af5", int'(fifo_count) == 6 ? int'(almost_full) : 0, 1);
    for (int i = 1; i <= 6; i++) cyc(0, 1, '0, 1, 12'h300 + 12'(i));

    repeat (2) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
